dma_reg_sequencer: RTL and testbench

//  Initiator for the DMA register interface; drives the register file from the CPU side.

---
 rtl/dma_pkg.sv | 41 ++++
 rtl/dma_seq_timer.sv | 28 ++
 rtl/dma_reg_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_dma_reg_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared DMA register-map constants plus the sequencer's state, completion and
// W1C-mask definitions.
package dma_pkg;

    localparam logic [3:0] REG_CONTROL    = 4'h0;
    localparam logic [3:0] REG_STATUS     = 4'h1;
    localparam logic [3:0] REG_INT_STATUS = 4'h2;
    localparam logic [3:0] REG_SRC_ADDR   = 4'h3;
    localparam logic [3:0] REG_DST_ADDR   = 4'h4;
    localparam logic [3:0] REG_LENGTH     = 4'h5;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_INT_EN = 1;

    localparam int unsigned STAT_DONE  = 1;
    localparam int unsigned STAT_ERROR = 2;

    typedef enum logic [3:0] {
        IDLE,
        WR_SRC,
        WR_DST,
        WR_LEN,
        WR_CTRL,
        WAIT_IRQ,
        POLL_WAIT,
        POLL_RD,
        RD_STAT,
        CLR,
        CMPL,
        ABORT
    } seq_state_e;

    typedef struct packed {
        logic timeout;
        logic error;
        logic done;
    } seq_cmpl_t;

    localparam logic [31:0] SEQ_W1C_MASK = 32'((1 << STAT_DONE) | (1 << STAT_ERROR));

endpackage

// File: rtl/dma_seq_timer.sv
// Loadable down-counter that stops at zero; used for the poll interval and the
// wait-state timeout.
module dma_seq_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (en_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/dma_reg_sequencer.sv
// DMA register-interface initiator: programs a channel from one descriptor, waits by
// IRQ or polling, clears INT_STATUS and reports completion. Option: DMA_SEQ_TIMEOUT_EN.
module dma_reg_sequencer
    import dma_pkg::*;
#(
    parameter int unsigned POLL_INTERVAL  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        desc_valid_i,
    output logic        desc_ready_o,
    input  logic [31:0] desc_src_i,
    input  logic [31:0] desc_dst_i,
    input  logic [15:0] desc_len_i,
    input  logic [7:0]  desc_ctrl_i,
    output logic        reg_write_o,
    output logic        reg_read_o,
    output logic [3:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic [31:0] reg_rdata_i,
    input  logic        irq_i,
    output logic        cmpl_valid_o,
    input  logic        cmpl_ready_i,
    output logic [2:0]  cmpl_status_o,
    output logic        busy_o
);

    localparam int unsigned POLL_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

    seq_state_e  r_state, w_state_nxt;
    logic [31:0] r_src, r_dst;
    logic [15:0] r_len;
    logic [7:0]  r_ctrl;
    logic        r_done, r_err;

    logic        r_desc_ready, r_busy, r_reg_write, r_reg_read, r_cmpl_valid;
    logic [3:0]  r_reg_addr;
    logic [31:0] r_reg_wdata;
    seq_cmpl_t   r_cmpl_status;

    logic        w_accept, w_stat_hit, w_timeout;
    logic        w_poll_load, w_poll_en, w_poll_zero;
    logic [31:0] w_src, w_dst;
    logic [15:0] w_len;
    logic [7:0]  w_ctrl;
    logic        w_wr, w_rd, w_cmpl_valid;
    logic [3:0]  w_addr;
    logic [31:0] w_wdata;
    seq_cmpl_t   w_cmpl_status;
    logic        w_unused;

    assign w_accept   = r_desc_ready && desc_valid_i;
    assign w_stat_hit = reg_rdata_i[STAT_DONE] | reg_rdata_i[STAT_ERROR];
    assign w_unused   = ^{reg_rdata_i[31:3], reg_rdata_i[0], TIMEOUT_CYCLES[0]};

    // Outputs are registered from the next state, so the descriptor fields are
    // forwarded from the ports on the accept edge.
    assign w_src  = w_accept ? desc_src_i  : r_src;
    assign w_dst  = w_accept ? desc_dst_i  : r_dst;
    assign w_len  = w_accept ? desc_len_i  : r_len;
    assign w_ctrl = w_accept ? desc_ctrl_i : r_ctrl;

    dma_seq_timer #(.W(POLL_W)) u_poll_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_poll_load),
        .load_val_i (POLL_W'(POLL_INTERVAL - 1)),
        .en_i       (w_poll_en),
        .zero_o     (w_poll_zero)
    );

`ifdef DMA_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic w_in_wait, w_to_load, w_to_en, w_to_zero, r_timeout;

    dma_seq_timer #(.W(TO_W)) u_to_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_to_load),
        .load_val_i (TO_W'(TIMEOUT_CYCLES - 1)),
        .en_i       (w_to_en),
        .zero_o     (w_to_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_timeout <= 1'b0;
        end else if (w_state_nxt == ABORT) begin
            r_timeout <= 1'b1;
        end
    end

    assign w_timeout = r_timeout;
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_poll_en   = 1'b0;
`ifdef DMA_SEQ_TIMEOUT_EN
        w_in_wait   = r_state inside {WAIT_IRQ, POLL_WAIT, POLL_RD, RD_STAT};
        w_to_load   = (r_state == WR_CTRL);
        w_to_en     = w_in_wait && !w_to_zero;
`endif
        case (r_state)
            IDLE:      if (w_accept) w_state_nxt = (desc_len_i == '0) ? CMPL : WR_SRC;
            WR_SRC:    w_state_nxt = WR_DST;
            WR_DST:    w_state_nxt = WR_LEN;
            WR_LEN:    w_state_nxt = WR_CTRL;
            WR_CTRL:   w_state_nxt = r_ctrl[CTRL_INT_EN] ? WAIT_IRQ : POLL_WAIT;
            WAIT_IRQ:  if (irq_i) w_state_nxt = RD_STAT;
            POLL_WAIT: begin
                if (w_poll_zero) w_state_nxt = POLL_RD;
                else             w_poll_en   = 1'b1;
            end
            POLL_RD:   w_state_nxt = w_stat_hit ? CLR : POLL_WAIT;
            RD_STAT:   w_state_nxt = w_stat_hit ? CLR : WAIT_IRQ;
            ABORT:     w_state_nxt = CLR;
            CLR:       w_state_nxt = CMPL;
            CMPL:      if (cmpl_ready_i) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
`ifdef DMA_SEQ_TIMEOUT_EN
        // A STATUS read that reports completion in the expiry cycle still wins.
        if (w_in_wait && w_to_zero && (w_state_nxt != CLR)) w_state_nxt = ABORT;
`endif
        w_poll_load = (w_state_nxt == POLL_WAIT) && (r_state != POLL_WAIT);

        w_wr          = 1'b0;
        w_rd          = 1'b0;
        w_addr        = '0;
        w_wdata       = '0;
        w_cmpl_valid  = 1'b0;
        w_cmpl_status = '0;
        case (w_state_nxt)
            WR_SRC:  begin w_wr = 1'b1; w_addr = REG_SRC_ADDR; w_wdata = w_src;            end
            WR_DST:  begin w_wr = 1'b1; w_addr = REG_DST_ADDR; w_wdata = w_dst;            end
            WR_LEN:  begin w_wr = 1'b1; w_addr = REG_LENGTH;   w_wdata = {16'h0, w_len};   end
            WR_CTRL: begin
                w_wr    = 1'b1;
                w_addr  = REG_CONTROL;
                w_wdata = {24'h0, w_ctrl | 8'(1 << CTRL_START)};
            end
            POLL_RD, RD_STAT: begin w_rd = 1'b1; w_addr = REG_STATUS; end
            ABORT:   begin w_wr = 1'b1; w_addr = REG_CONTROL;    w_wdata = '0;           end
            CLR:     begin w_wr = 1'b1; w_addr = REG_INT_STATUS; w_wdata = SEQ_W1C_MASK; end
            CMPL: begin
                w_cmpl_valid = 1'b1;
                if (!w_accept) w_cmpl_status = '{timeout: w_timeout, error: r_err, done: r_done};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_src         <= '0;
            r_dst         <= '0;
            r_len         <= '0;
            r_ctrl        <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_desc_ready  <= 1'b1;
            r_busy        <= 1'b0;
            r_reg_write   <= 1'b0;
            r_reg_read    <= 1'b0;
            r_reg_addr    <= '0;
            r_reg_wdata   <= '0;
            r_cmpl_valid  <= 1'b0;
            r_cmpl_status <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_desc_ready  <= (w_state_nxt == IDLE);
            r_busy        <= (w_state_nxt != IDLE);
            r_reg_write   <= w_wr;
            r_reg_read    <= w_rd;
            r_reg_addr    <= w_addr;
            r_reg_wdata   <= w_wdata;
            r_cmpl_valid  <= w_cmpl_valid;
            r_cmpl_status <= w_cmpl_status;
            if (w_accept) begin
                r_src  <= desc_src_i;
                r_dst  <= desc_dst_i;
                r_len  <= desc_len_i;
                r_ctrl <= desc_ctrl_i;
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end else if (r_state inside {POLL_RD, RD_STAT}) begin
                r_done <= reg_rdata_i[STAT_DONE];
                r_err  <= reg_rdata_i[STAT_ERROR];
            end
        end
    end

    assign desc_ready_o  = r_desc_ready;
    assign busy_o        = r_busy;
    assign reg_write_o   = r_reg_write;
    assign reg_read_o    = r_reg_read;
    assign reg_addr_o    = r_reg_addr;
    assign reg_wdata_o   = r_reg_wdata;
    assign cmpl_valid_o  = r_cmpl_valid;
    assign cmpl_status_o = r_cmpl_status;

endmodule

// File: tb/tb_dma_reg_sequencer.sv
// Scoreboard bench: stimulus queues expected strobes/completions with their cycle,
// a monitor pops and compares whenever the DUT presents one.
module tb_dma_reg_sequencer;
    import dma_pkg::*;

    localparam int unsigned PI = 4;
    localparam int unsigned TO = 32;
    localparam int KW = 0, KR = 1, KC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        desc_valid_i, desc_ready_o;
    logic [31:0] desc_src_i, desc_dst_i;
    logic [15:0] desc_len_i;
    logic [7:0]  desc_ctrl_i;
    logic        reg_write_o, reg_read_o;
    logic [3:0]  reg_addr_o;
    logic [31:0] reg_wdata_o, reg_rdata_i;
    logic        irq_i, cmpl_valid_o, cmpl_ready_i, busy_o;
    logic [2:0]  cmpl_status_o;

    dma_reg_sequencer #(.POLL_INTERVAL(PI), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_src_i(desc_src_i), .desc_dst_i(desc_dst_i),
        .desc_len_i(desc_len_i), .desc_ctrl_i(desc_ctrl_i),
        .reg_write_o(reg_write_o), .reg_read_o(reg_read_o),
        .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i),
        .irq_i(irq_i), .cmpl_valid_o(cmpl_valid_o), .cmpl_ready_i(cmpl_ready_i),
        .cmpl_status_o(cmpl_status_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        logic [3:0]  addr;
        logic [31:0] data;
        int unsigned cyc;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] stat_q[$];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input logic [3:0] a, input logic [31:0] d,
                           input int unsigned c);
        ev_t e;
        e.kind = kind; e.addr = a; e.data = d; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Monitor: samples 2 time units after the falling edge, answers STATUS reads.
    initial begin
        reg_rdata_i = '0;
        forever begin
            @(negedge clk);
            #2;
            reg_rdata_i = '0;
            if (rst_n === 1'b1) begin
                if (reg_write_o || reg_read_o) begin
                    check("single_strobe", {31'b0, reg_write_o & reg_read_o}, 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: got addr 0x%0h wr=%0b rd=%0b, none expected (cycle %0d)",
                                 reg_addr_o, reg_write_o, reg_read_o, cyc);
                    end else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        check("strobe_kind", reg_write_o ? KW : KR, e.kind);
                        check("strobe_addr", {28'b0, reg_addr_o}, {28'b0, e.addr});
                        if (reg_write_o) check("strobe_wdata", reg_wdata_o, e.data);
                        check("strobe_cycle", cyc, e.cyc);
                    end
                    if (reg_read_o) reg_rdata_i = (stat_q.size() != 0) ? stat_q.pop_front() : '0;
                end
                if (cmpl_valid_o && cmpl_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cmpl: got status 0x%0h, none expected (cycle %0d)",
                                 cmpl_status_o, cyc);
                    end else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        check("cmpl_kind", KC, e.kind);
                        check("cmpl_status", {29'b0, cmpl_status_o}, e.data);
                        check("cmpl_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic wait_until(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain(input int unsigned budget);
        for (int unsigned i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #3;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending events, required 0 (cycle %0d)",
                     exp_q.size(), cyc);
            exp_q.delete();
        end
    endtask

    task automatic send(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                        input logic [7:0] c, input logic [31:0] exp_ctrl,
                        output int unsigned k0);
        @(negedge clk);
        check("desc_ready_idle", {31'b0, desc_ready_o}, 32'd1);
        k0 = cyc;
        desc_valid_i = 1'b1;
        desc_src_i = s; desc_dst_i = d; desc_len_i = l; desc_ctrl_i = c;
        if (l != 16'd0) begin
            push_ev(KW, REG_SRC_ADDR, s, k0 + 1);
            push_ev(KW, REG_DST_ADDR, d, k0 + 2);
            push_ev(KW, REG_LENGTH, {16'h0, l}, k0 + 3);
            push_ev(KW, REG_CONTROL, exp_ctrl, k0 + 4);
        end
        @(negedge clk);
        desc_valid_i = 1'b0;
    endtask

    task automatic irq_pulse();
        irq_i = 1'b1;
        @(negedge clk);
        irq_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k0, k1, k2;
        rst_n = 1'b0;
        desc_valid_i = 1'b0; desc_src_i = '0; desc_dst_i = '0; desc_len_i = '0; desc_ctrl_i = '0;
        irq_i = 1'b0; cmpl_ready_i = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_desc_ready", {31'b0, desc_ready_o}, 32'd1);
        check("rst_write", {31'b0, reg_write_o}, 32'd0);
        check("rst_read", {31'b0, reg_read_o}, 32'd0);
        check("rst_addr", {28'b0, reg_addr_o}, 32'd0);
        check("rst_wdata", reg_wdata_o, 32'd0);
        check("rst_cmpl_valid", {31'b0, cmpl_valid_o}, 32'd0);
        check("rst_cmpl_status", {29'b0, cmpl_status_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        rst_n = 1'b1;

        // IRQ mode, STATUS=done
        send(32'h1000, 32'h2000, 16'd16, 8'h02, 32'h3, k0);
        wait_until(k0 + 8);
        check("busy_wait_irq", {31'b0, busy_o}, 32'd1);
        check("no_cmpl_wait_irq", {31'b0, cmpl_valid_o}, 32'd0);
        k1 = cyc;
        stat_q.push_back(32'h2);
        push_ev(KR, REG_STATUS, '0, k1 + 1);
        push_ev(KW, REG_INT_STATUS, 32'h6, k1 + 2);
        push_ev(KC, '0, 32'h1, k1 + 3);
        irq_pulse();
        drain(40);
        check("ready_low_in_cmpl", {31'b0, desc_ready_o}, 32'd0);
        @(negedge clk);
        check("ready_after_handshake", {31'b0, desc_ready_o}, 32'd1);
        check("busy_after_handshake", {31'b0, busy_o}, 32'd0);

        // Poll mode, STATUS 1,1,4 -> error
        send(32'h3000, 32'h4000, 16'd8, 8'h00, 32'h1, k0);
        stat_q.push_back(32'h1); stat_q.push_back(32'h1); stat_q.push_back(32'h4);
        push_ev(KR, REG_STATUS, '0, k0 + 9);
        push_ev(KR, REG_STATUS, '0, k0 + 14);
        push_ev(KR, REG_STATUS, '0, k0 + 19);
        push_ev(KW, REG_INT_STATUS, 32'h6, k0 + 20);
        push_ev(KC, '0, 32'h2, k0 + 21);
        drain(60);

        // Zero length: completion in the next cycle, no register access
        send(32'h5000, 32'h6000, 16'd0, 8'h02, 32'h0, k0);
        push_ev(KC, '0, 32'h0, k0 + 1);
        drain(10);

        // Spurious IRQ, then done+error, completion stalled 10 cycles
        cmpl_ready_i = 1'b0;
        send(32'h7000, 32'h8000, 16'd4, 8'h12, 32'h13, k0);
        wait_until(k0 + 7);
        k1 = cyc;
        stat_q.push_back(32'h1);
        push_ev(KR, REG_STATUS, '0, k1 + 1);
        irq_pulse();
        wait_until(k1 + 4);
        k2 = cyc;
        stat_q.push_back(32'h6);
        push_ev(KR, REG_STATUS, '0, k2 + 1);
        push_ev(KW, REG_INT_STATUS, 32'h6, k2 + 2);
        irq_pulse();
        wait_until(k2 + 3);
        for (int i = 0; i < 10; i++) begin
            #3;
            check("stall_cmpl_valid", {31'b0, cmpl_valid_o}, 32'd1);
            check("stall_cmpl_status", {29'b0, cmpl_status_o}, 32'h3);
            check("stall_desc_ready", {31'b0, desc_ready_o}, 32'd0);
            @(negedge clk);
        end
        push_ev(KC, '0, 32'h3, cyc);
        cmpl_ready_i = 1'b1;
        drain(10);

`ifdef DMA_SEQ_TIMEOUT_EN
        // Poll mode with STATUS stuck busy -> abort after TO wait cycles
        send(32'h9000, 32'hA000, 16'd32, 8'h00, 32'h1, k0);
        for (int unsigned i = 0; i < 6; i++) begin
            stat_q.push_back(32'h1);
            push_ev(KR, REG_STATUS, '0, k0 + 9 + 5 * i);
        end
        push_ev(KW, REG_CONTROL, 32'h0, k0 + 37);
        push_ev(KW, REG_INT_STATUS, 32'h6, k0 + 38);
        push_ev(KC, '0, 32'h4, k0 + 39);
        drain(80);
`endif

        // Reset while the DST write is on the bus
        send(32'hB000, 32'hC000, 16'd4, 8'h02, 32'h3, k0);
        @(negedge clk);
        check("pre_reset_write", {31'b0, reg_write_o}, 32'd1);
        check("pre_reset_addr", {28'b0, reg_addr_o}, {28'b0, REG_DST_ADDR});
        rst_n = 1'b0;
        #1;
        check("mid_rst_write", {31'b0, reg_write_o}, 32'd0);
        check("mid_rst_read", {31'b0, reg_read_o}, 32'd0);
        check("mid_rst_cmpl", {31'b0, cmpl_valid_o}, 32'd0);
        check("mid_rst_ready", {31'b0, desc_ready_o}, 32'd1);
        check("mid_rst_busy", {31'b0, busy_o}, 32'd0);
        check("pending_after_rst", exp_q.size(), 32'd3);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(32'hD000, 32'hE000, 16'd0, 8'h00, 32'h0, k0);
        push_ev(KC, '0, 32'h0, k0 + 1);
        drain(10);

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
